// File: rtl/uart_pkg.sv
// Shared definitions for the bus_uart peripheral:
// register offsets, status bit positions and serial FSM states.
package uart_pkg;

  localparam logic REG_DATA   = 1'b0;
  localparam logic REG_STATUS = 1'b1;

  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_IDLE    = 1;
  localparam int ST_RX_VALID   = 2;
  localparam int ST_RX_OVERRUN = 3;
  localparam int ST_RX_FRAMING = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } ser_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous TX FIFO; head word is visible combinationally.
// A push while full is accepted only when a pop happens on the same edge.
module uart_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic [AW-1:0]  r_wr;
  logic [AW-1:0]  r_rd;
  logic [AW:0]    r_cnt;
  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];

  logic w_push;
  logic w_pop;

  assign o_full  = (r_cnt == FULL_CNT);
  assign o_empty = (r_cnt == '0);
  assign o_data  = r_mem[r_rd];
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop)
        r_rd <= r_rd + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/bus_uart.sv
// Memory-mapped 8N1 UART: DATA/STATUS registers, TX FIFO + serialiser.
// Define UART_RX_EN to build the receive path (sync, RX FSM, holding reg).
module bus_uart
  import uart_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'hF200,
  parameter int          CLOCK_HZ   = 5062500,
  parameter int          BAUD       = 9600,
  parameter int          DIVISOR    = (CLOCK_HZ + BAUD/2) / BAUD,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [18:0] address,
  input  logic        write_en,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        selected,
  output logic        tx,
  input  logic        rx
);

  localparam int DW = $clog2(DIVISOR);
  localparam logic [DW-1:0] DIV_END  = DW'(DIVISOR - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(DIVISOR/2 - 1);

  logic       w_reg;
  logic       w_data_wr;
  logic       w_stat_wr;
  logic [7:0] w_status;
  logic [7:0] w_rx_data;
  logic [2:0] w_rx_flags;
  logic       w_unused;

  assign selected  = (address[15:1] == BASE_ADDR[15:1]);
  assign w_reg     = address[0];
  assign w_data_wr = write_en & selected & (w_reg == REG_DATA);
  assign w_stat_wr = write_en & selected & (w_reg == REG_STATUS);

  logic       w_fifo_full;
  logic       w_fifo_empty;
  logic [7:0] w_fifo_head;
  logic       w_tx_pop;

  uart_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (8)
  ) u_fifo (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_push  (w_data_wr),
    .i_data  (data_in),
    .i_pop   (w_tx_pop),
    .o_data  (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  ser_state_t    r_tx_state;
  ser_state_t    w_tx_next;
  logic [DW-1:0] r_tx_div;
  logic [2:0]    r_tx_bit;
  logic [7:0]    r_tx_shift;
  logic          w_tx_div_end;

  assign w_tx_div_end = (r_tx_div == DIV_END);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tx_state <= S_IDLE;
      r_tx_div   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
    end else begin
      r_tx_state <= w_tx_next;
      if (w_tx_pop) begin
        r_tx_shift <= w_fifo_head;
        r_tx_div   <= '0;
        r_tx_bit   <= '0;
      end else if (r_tx_state != S_IDLE) begin
        if (w_tx_div_end) begin
          r_tx_div <= '0;
          if (r_tx_state == S_DATA) begin
            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
            r_tx_bit   <= r_tx_bit + 3'd1;
          end
        end else begin
          r_tx_div <= r_tx_div + DW'(1);
        end
      end
    end
  end

  always_comb begin
    w_tx_next = r_tx_state;
    unique case (r_tx_state)
      S_IDLE:
        if (!w_fifo_empty) w_tx_next = S_START;
      S_START:
        if (w_tx_div_end) w_tx_next = S_DATA;
      S_DATA:
        if (w_tx_div_end && r_tx_bit == 3'd7)
          w_tx_next = S_STOP;
      S_STOP:
        if (w_tx_div_end)
          w_tx_next = w_fifo_empty ? S_IDLE : S_START;
      default: w_tx_next = S_IDLE;
    endcase
  end

  // STOP hands straight to the next queued byte, so frames abut
  always_comb begin
    tx       = 1'b1;
    w_tx_pop = 1'b0;
    unique case (r_tx_state)
      S_IDLE:  w_tx_pop = ~w_fifo_empty;
      S_START: tx = 1'b0;
      S_DATA:  tx = r_tx_shift[0];
      S_STOP:  w_tx_pop = w_tx_div_end & ~w_fifo_empty;
      default: ;
    endcase
  end

`ifdef UART_RX_EN
  logic          r_rx_s1;
  logic          r_rx_s2;
  logic          r_rx_prev;
  ser_state_t    r_rx_state;
  ser_state_t    w_rx_next;
  logic [DW-1:0] r_rx_div;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_shift;
  logic [7:0]    r_rx_data;
  logic          r_rx_valid;
  logic          r_rx_overrun;
  logic          r_rx_framing;
  logic          w_rx_div_end;
  logic          w_rx_half;
  logic          w_rx_restart;
  logic          w_rx_sample;
  logic          w_rx_ok;
  logic          w_rx_ferr;

  assign w_rx_div_end = (r_rx_div == DIV_END);
  assign w_rx_half    = (r_rx_div == DIV_HALF);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_state <= S_IDLE;
      r_rx_div   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_s1    <= rx;
      r_rx_s2    <= r_rx_s1;
      r_rx_prev  <= r_rx_s2;
      r_rx_state <= w_rx_next;
      if (r_rx_state == S_IDLE || w_rx_restart)
        r_rx_div <= '0;
      else
        r_rx_div <= r_rx_div + DW'(1);
      if (r_rx_state == S_START)
        r_rx_bit <= '0;
      if (w_rx_sample) begin
        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
        r_rx_bit   <= r_rx_bit + 3'd1;
      end
    end
  end

  always_comb begin
    w_rx_next = r_rx_state;
    unique case (r_rx_state)
      S_IDLE:
        if (r_rx_prev && !r_rx_s2) w_rx_next = S_START;
      S_START:
        if (w_rx_half)
          w_rx_next = r_rx_s2 ? S_IDLE : S_DATA;
      S_DATA:
        if (w_rx_div_end && r_rx_bit == 3'd7)
          w_rx_next = S_STOP;
      S_STOP:
        if (w_rx_div_end) w_rx_next = S_IDLE;
      default: w_rx_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_rx_restart = 1'b0;
    w_rx_sample  = 1'b0;
    w_rx_ok      = 1'b0;
    w_rx_ferr    = 1'b0;
    unique case (r_rx_state)
      S_START: w_rx_restart = w_rx_half;
      S_DATA: begin
        w_rx_restart = w_rx_div_end;
        w_rx_sample  = w_rx_div_end;
      end
      S_STOP: begin
        w_rx_restart = w_rx_div_end;
        w_rx_ok      = w_rx_div_end & r_rx_s2;
        w_rx_ferr    = w_rx_div_end & ~r_rx_s2;
      end
      default: ;
    endcase
  end

  // A completing frame overrides a same-edge STATUS clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_rx_overrun <= 1'b0;
      r_rx_framing <= 1'b0;
    end else begin
      if (w_stat_wr) begin
        r_rx_valid   <= 1'b0;
        r_rx_overrun <= 1'b0;
        r_rx_framing <= 1'b0;
      end
      if (w_rx_ok) begin
        r_rx_data  <= r_rx_shift;
        r_rx_valid <= 1'b1;
        if (r_rx_valid)
          r_rx_overrun <= 1'b1;
      end
      if (w_rx_ferr)
        r_rx_framing <= 1'b1;
    end
  end

  assign w_rx_data  = r_rx_data;
  assign w_rx_flags = {r_rx_framing, r_rx_overrun, r_rx_valid};
  assign w_unused   = ^address[18:16];
`else
  assign w_rx_data  = '0;
  assign w_rx_flags = '0;
  assign w_unused   = ^{address[18:16], rx, w_stat_wr};
`endif

  always_comb begin
    w_status                = '0;
    w_status[ST_TX_FULL]    = w_fifo_full;
    w_status[ST_TX_IDLE]    = w_fifo_empty &
                              (r_tx_state == S_IDLE);
    w_status[ST_RX_VALID]   = w_rx_flags[0];
    w_status[ST_RX_OVERRUN] = w_rx_flags[1];
    w_status[ST_RX_FRAMING] = w_rx_flags[2];
  end

  always_comb begin
    data_out = '0;
    if (selected)
      data_out = (w_reg == REG_STATUS) ? w_status : w_rx_data;
  end

endmodule

// File: tb/tb_bus_uart.sv
// Scoreboard bench for bus_uart (CLOCK_HZ=16, BAUD=1 -> 16 clocks/bit).
// A tx monitor decodes frames and checks them against a queue of expected bytes.
module tb_bus_uart;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [18:0] address = '0;
  logic        write_en = 1'b0;
  logic [7:0]  data_in = '0;
  logic [7:0]  data_out;
  logic        selected;
  logic        tx;
  logic        rx = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [7:0] d;
    bit         gap;
  } exp_t;

  exp_t q[$];

  localparam logic [18:0] A_DATA = 19'h0F200;
  localparam logic [18:0] A_STAT = 19'h0F201;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bus_uart #(
    .CLOCK_HZ (16),
    .BAUD     (1)
  ) dut (
    .clock    (clk),
    .reset    (rst_n),
    .address  (address),
    .write_en (write_en),
    .data_in  (data_in),
    .data_out (data_out),
    .selected (selected),
    .tx       (tx),
    .rx       (rx)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [18:0] a,
                    input logic [7:0] exp,
                    input string nm);
    @(negedge clk);
    address = a;
    #1 chk(nm, data_out, exp);
  endtask

  task automatic wr(input logic [18:0] a, input logic [7:0] d);
    @(negedge clk);
    address  = a;
    data_in  = d;
    write_en = 1'b1;
    @(negedge clk);
    write_en = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    idle(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      idle(16);
    end
    rx = stop;
    idle(16);
    rx = 1'b1;
  endtask

  task automatic push_exp(input logic [7:0] d, input bit g);
    exp_t e;
    e.d   = d;
    e.gap = g;
    q.push_back(e);
  endtask

  // Waits n falling edges, abandoning the frame if reset is asserted
  task automatic wait_neg(input int n, inout bit ab);
    for (int j = 0; j < n; j++) begin
      if (ab) break;
      @(negedge clk);
      if (!rst_n) ab = 1'b1;
    end
  endtask

  initial begin : mon
    int         st;
    int         prev_st;
    bit         ab;
    logic [7:0] b;
    logic       s0;
    logic       sb;
    exp_t       e;
    prev_st = -100000;
    forever begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
        st = cyc;
        ab = 1'b0;
        wait_neg(8, ab);
        s0 = tx;
        for (int i = 0; i < 8; i++) begin
          wait_neg(16, ab);
          b[i] = tx;
        end
        wait_neg(16, ab);
        sb = tx;
        if (!ab) begin
          if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL frame_unexp: got %0h expected none", b);
          end else begin
            e = q.pop_front();
            chk("frame_data", b, e.d);
            chk("frame_start", s0, 0);
            chk("frame_stop", sb, 1);
            if (e.gap)
              chk("frame_gap", st - prev_st, 160);
          end
          prev_st = st;
          wait_neg(7, ab);
        end
      end
    end
  end

  initial begin
    // reset state
    #1 chk("rst_tx", tx, 1);
    address = A_STAT;
    #1 chk("rst_status", data_out, 8'h02);
    idle(3);
    rst_n = 1'b1;
    idle(3);
    rd(A_STAT, 8'h02, "status_after_rst");
    rd(A_DATA, 8'h00, "data_after_rst");

    // reset mid-frame with a second byte still queued
    @(negedge clk);
    address  = A_DATA;
    data_in  = 8'h55;
    write_en = 1'b1;
    @(negedge clk);
    data_in  = 8'h33;
    @(negedge clk);
    write_en = 1'b0;
    idle(60);
    #2 rst_n = 1'b0;
    #1 chk("midrst_tx", tx, 1);
    address = A_STAT;
    #1 chk("midrst_status", data_out, 8'h02);
    idle(3);
    rst_n = 1'b1;
    idle(200);
    rd(A_STAT, 8'h02, "midrst_status_after");

    // single send and latency
    push_exp(8'hA5, 1'b0);
    wr(A_DATA, 8'hA5);
    chk("tx_before_pop", tx, 1);
    @(negedge clk);
    chk("tx_start_low", tx, 0);
    idle(170);
    rd(A_STAT, 8'h02, "single_idle");

    // FIFO full, drop of sixth write, back-to-back frames
    push_exp(8'h01, 1'b0);
    for (int i = 2; i <= 5; i++)
      push_exp(8'(i), 1'b1);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      address  = A_DATA;
      data_in  = 8'(i);
      write_en = 1'b1;
    end
    @(negedge clk);
    write_en = 1'b0;
    address  = A_STAT;
    #1 chk("fifo_full", data_out, 8'h01);
    idle(850);
    rd(A_STAT, 8'h02, "fifo_drained");

    // address decode
    @(negedge clk);
    address  = 19'h0F202;
    data_in  = 8'h11;
    write_en = 1'b1;
    #1 chk("sel_miss", selected, 0);
    @(negedge clk);
    address  = 19'h1F200;
    data_in  = 8'h5A;
    #1 chk("sel_alias", selected, 1);
    push_exp(8'h5A, 1'b0);
    @(negedge clk);
    write_en = 1'b0;
    idle(200);

`ifdef UART_RX_EN
    send_rx(8'h3C, 1'b1);
    idle(4);
    rd(A_STAT, 8'h06, "rx_valid");
    rd(A_DATA, 8'h3C, "rx_data1");
    send_rx(8'h7E, 1'b1);
    idle(4);
    rd(A_STAT, 8'h0E, "rx_overrun");
    rd(A_DATA, 8'h7E, "rx_data2");
    wr(A_STAT, 8'h00);
    rd(A_STAT, 8'h02, "rx_clear");
    @(negedge clk);
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(40);
    rd(A_STAT, 8'h02, "rx_glitch");
    send_rx(8'h99, 1'b0);
    idle(4);
    rd(A_STAT, 8'h12, "rx_framing");
    rd(A_DATA, 8'h7E, "rx_frame_discard");
`else
    send_rx(8'h3C, 1'b1);
    idle(4);
    rd(A_DATA, 8'h00, "norx_data");
    rd(A_STAT, 8'h02, "norx_status");
    wr(A_STAT, 8'hFF);
    rd(A_STAT, 8'h02, "norx_stat_wr");
`endif

    idle(20);
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_uart.md
Name: bus_uart

Overview:
- Memory-mapped 8N1 UART peripheral on the CPU6 system bus, sitting beside the LED panel and block RAM.
- CPU stores to its data register feed a TX FIFO that is serialised onto a pin.
- An optional receive path deserialises an input pin into a holding register.
- Read data is driven combinationally with a select flag, so the top level can mux it onto the CPU read bus.

Parameters:
- BASE_ADDR, 16'hF200: bus address of register 0; compared against address[15:0], address[18:16] ignored.
- CLOCK_HZ, 5062500: clock frequency (20.25 MHz / 4).
- BAUD, 9600: line rate.
- DIVISOR, (CLOCK_HZ+BAUD/2)/BAUD = 527: clocks per bit, minimum 4.
- FIFO_DEPTH, 4: TX FIFO entries; power of two, 2..16.

Ports:
- clock  in  1  system bus clock.
- reset  in  1  asynchronous, active-low reset.
- address  in  19  CPU address bus.
- write_en  in  1  CPU write strobe, sampled on rising clock.
- data_in  in  8  CPU write data.
- data_out  out  8  register read data, combinational; 0 when not selected.
- selected  out  1  address[15:1]==BASE_ADDR[15:1], combinational.
- tx  out  1  serial output, idle high.
- rx  in  1  serial input, asynchronous.

Behaviour:
- Register map:
  - +0 DATA: write pushes data_in[7:0] into the TX FIFO; read returns the RX holding byte.
  - +1 STATUS: read bits are [0] tx_full, [1] tx_idle (FIFO empty and FSM IDLE), [2] rx_valid, [3] rx_overrun, [4] rx_framing, [7:5]=0; any write clears bits 2..4.
- Reads have no side effects.
- Reset (async assert, any time, including mid-frame): tx=1, FIFO empty, TX FSM IDLE, RX FSM IDLE, holding byte=0, all flags 0, bit counter and divider counter 0. Deassertion takes effect on the next clock edge.
- TX FIFO:
  - A push at write edge N is visible at N+1.
  - A push while full is dropped, except when a pop occurs on the same edge, in which case it is accepted.
  - Occupancy counter is log2(FIFO_DEPTH)+1 bits; read and write pointers wrap modulo FIFO_DEPTH.
- TX FSM, states IDLE -> START -> DATA -> STOP -> IDLE:
  - IDLE with FIFO non-empty: pop the head into the shift register, enter START, tx=0.
  - Latency: a write to an empty FIFO with FSM IDLE at edge N gives tx low after edge N+1.
  - Each state holds for DIVISOR clocks.
  - DATA sends 8 bits LSB first.
  - STOP drives tx=1 for DIVISOR clocks. On exit, if the FIFO is non-empty, pop immediately into START (back-to-back frames with no idle gap); otherwise go to IDLE.
- RX FSM (UART_RX_EN only), states IDLE -> START -> DATA -> STOP:
  - rx passes through a 2-flop synchroniser.
  - IDLE: a synchronised 1->0 transition enters START.
  - START: after DIVISOR/2 clocks, resample. Low: enter DATA. High: false start, back to IDLE with no flag change.
  - DATA: sample 8 bits at DIVISOR intervals, LSB first.
  - STOP: sample after DIVISOR clocks.
    - High: load the holding byte and set rx_valid. If rx_valid was already set, overwrite and set rx_overrun.
    - Low: discard the byte, set rx_framing.
  - From STOP, return to IDLE.
- Simultaneous STATUS write and RX completion on the same edge: the completion wins, so its flags are set.

Optional Feature:
- UART_RX_EN defined: RX synchroniser, RX FSM and holding register are present as described.
- UART_RX_EN undefined: rx is ignored, DATA reads 0, STATUS bits 2..4 read 0, STATUS writes have no effect.

Decomposition:
- Package uart_pkg holds:
  - register offsets REG_DATA=0, REG_STATUS=1;
  - status bit indices ST_TX_FULL..ST_RX_FRAMING;
  - the shared serial FSM state encoding (IDLE, START, DATA, STOP).
- One sub-module, uart_fifo: synchronous FIFO with push/pop/full/empty, parameter FIFO_DEPTH, async active-low reset.
- TX and RX FSMs stay inline in bus_uart.

Test Plan (bench uses CLOCK_HZ=16, BAUD=1, so DIVISOR=16):
- Reset mid-frame: reset low while tx is in DATA -> tx=1 immediately, STATUS reads 8'h02, no further frame after release.
- Single send: write 8'hA5 to BASE_ADDR -> tx low one clock after the write edge, then bits 1,0,1,0,0,1,0,1 at 16-clock intervals, stop high, STATUS bit1=1 after 160 clocks.
- FIFO full: 6 back-to-back writes 8'h01..8'h06 with depth 4 -> STATUS bit0=1 after the 5th write. Then 5 frames 01..05 go out back-to-back with no idle gap: the first is popped before the 5th write, and the 6th write is dropped.
- RX receive: drive frame 8'h3C on rx -> STATUS bit2=1, DATA reads 8'h3C. A second frame 8'h7E before the clear -> DATA=8'h7E, bit3=1. A STATUS write then -> bits 2..4 clear.
- RX errors: 4-clock low glitch on rx -> no flags set. Frame with stop bit low -> bit4=1, bit2 unchanged.
- Decode: write to 16'hF202 and to 19'h1F200 -> the first is ignored with selected=0; the second (address[18:16] ignored) pushes with selected=1.
